csl_add_arbiter: RTL and testbench
==================================

Name: csl_add_arbiter

Overview:
- Shares one 23-bit carry-select adder instance (csl23bit) between NREQ requesters.
- Round-robin arbitration with a valid/ready request per requester.
- Operands are registered; one result per transaction comes back on a single valid/ready response channel, tagged with the requester ID.
- Sits between the mantissa-path clients and the shared adder, so only one adder copy exists per cluster.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), requester ID width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept; at most one bit set.
- req_a  in  NREQ*23  operand A; requester i uses bits [23*i+22:23*i].
- req_b  in  NREQ*23  operand B, same packing.
- req_cin  in  NREQ  carry-in per requester.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts result.
- rsp_sum  out  23  registered sum.
- rsp_cout  out  1  registered carry-out.
- rsp_id  out  IDW  index of the requester that owns the result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- One clock; reset is asynchronous and active-high on rst.
- Reset values:
  - state=IDLE, rr_ptr=0.
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, busy=0.
  - Operand registers cleared.
  - req_ready=0 while rst is high.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational and one-hot: the first set req_valid bit scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - No valid requests gives req_ready=0.
  - A handshake (req_valid[i] & req_ready[i]) captures A, B, cin and id=i. Next: rr_ptr=(i+1) mod NREQ, state=EXEC.
- EXEC:
  - The adder is driven only from the captured operand registers.
  - sum/cout/id are registered into the rsp_* registers and rsp_valid is set. Next state RESP.
  - req_ready=0.
- RESP:
  - rsp_valid=1; rsp_sum, rsp_cout and rsp_id are held stable until handshake.
  - On rsp_ready=1: rsp_valid clears next cycle. In the same cycle the arbiter runs exactly as in IDLE (req_ready may assert).
    - If a request is granted, go to EXEC.
    - Otherwise go to IDLE.
  - With rsp_ready=0: req_ready=0 and the state stays RESP indefinitely.
- Latency and throughput:
  - Request handshake at cycle t gives rsp_valid=1 at t+2.
  - Sustained throughput is one result per 2 cycles when rsp_ready is held high.
- Arithmetic: {rsp_cout, rsp_sum} = A + B + cin, exact 24-bit result, no saturation.
  - Example: A=0x7FFFFF, B=1, cin=0 gives sum=0, cout=1.
- Requester rules:
  - A requester may drop req_valid before it is granted. The arbiter samples only the current cycle, with no memory of past requests.
  - Operands must be stable only in the handshake cycle.
- Fairness: a continuously requesting client is served within NREQ grants.
- Simultaneous events: the RESP rsp_ready handshake and the new grant in the same cycle are legal and required (back-to-back case).
- Reset mid-operation: in-flight work is discarded, with no response emitted. All outputs return to reset values immediately (async). rr_ptr returns to 0.
- The adder's combinational output is never exposed directly; all outputs are registered except req_ready.

Decomposition:
- Shared package csl_pkg:
  - ADD_W=23 constant.
  - State enum (IDLE/EXEC/RESP) as localparams.
- Sub-module rr_arbiter (NREQ, combinational one-hot grant from req vector plus pointer) sits next to the FSM.
- csl23bit is instantiated unchanged as the datapath.

Test Plan:
- Single request: reset, req_valid[2]=1 with A=0x000005, B=0x000003, cin=1, rsp_ready=1.
  - Expected: req_ready=0b0100 in the handshake cycle.
  - Expected: 2 cycles later rsp_valid=1, rsp_sum=0x000009, rsp_cout=0, rsp_id=2.
- Carry-out: A=0x7FFFFF, B=0x000001, cin=0.
  - Expected: rsp_sum=0x000000, rsp_cout=1. Also A=B=0x7FFFFF, cin=1 gives sum=0x7FFFFF, cout=1.
- Round-robin: all four req_valid held high, rsp_ready=1.
  - Expected: grants in order 0,1,2,3,0, each 2 cycles apart; rsp_id sequence matches.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid.
  - Expected: rsp_sum/cout/id stable, req_ready=0 throughout.
  - Then rsp_ready=1 with req_valid[1]=1: handshake and grant occur in the same cycle.
- Reset mid-operation: assert rst during EXEC.
  - Expected: rsp_valid=0 and busy=0 immediately, no response after release, next grant starts from requester 0.

Source files
------------

// File: rtl/csl_add_arbiter_pkg.sv
// Shared constants and FSM encoding for the shared carry-select adder
// arbiter and its datapath.
package csl_pkg;

    localparam int ADD_W = 23;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t EXEC = 2'd1;
    localparam state_t RESP = 2'd2;

endpackage

// File: rtl/csl23bit.sv
// 23-bit carry-select adder: an 8-bit ripple head followed by two
// speculative blocks whose results are picked by the incoming carry.
module csl23bit (
    input  logic [22:0] a,
    input  logic [22:0] b,
    input  logic        cin,
    output logic [22:0] sum,
    output logic        cout
);

    logic [8:0] s0;
    logic [8:0] s1_0, s1_1, s1;
    logic [7:0] s2_0, s2_1, s2;

    assign s0   = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin};

    assign s1_0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
    assign s1_1 = {1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'd1;
    assign s1   = s0[8] ? s1_1 : s1_0;

    assign s2_0 = {1'b0, a[22:16]} + {1'b0, b[22:16]};
    assign s2_1 = {1'b0, a[22:16]} + {1'b0, b[22:16]} + 8'd1;
    assign s2   = s1[8] ? s2_1 : s2_0;

    assign sum  = {s2[6:0], s1[7:0], s0[7:0]};
    assign cout = s2[7];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first set
// request at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/csl_add_arbiter.sv
// Round-robin front end sharing one csl23bit between NREQ requesters,
// with registered operands and a tagged valid/ready response channel.
module csl_add_arbiter
    import csl_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*ADD_W-1:0] req_a,
    input  logic [NREQ*ADD_W-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADD_W-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
);

    state_t         state, nstate;
    logic [IDW-1:0] rr_ptr;

    logic [ADD_W-1:0] op_a, op_b;
    logic             op_cin;
    logic [IDW-1:0]   op_id;

    logic [NREQ-1:0]  arb_gnt;
    logic [IDW-1:0]   arb_id;
    logic             arb_en;
    logic             hs;

    logic [ADD_W-1:0] add_sum;
    logic             add_cout;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .gnt    (arb_gnt),
        .gnt_id (arb_id)
    );

    csl23bit u_add (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Arbitration is open in IDLE and in the cycle a response retires.
    assign arb_en = (state == IDLE) || (state == RESP && rsp_ready);
    assign hs     = |req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = hs ? EXEC : IDLE;
            EXEC:    nstate = RESP;
            RESP:    if (rsp_ready) nstate = hs ? EXEC : IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (arb_en && !rst) req_ready = arb_gnt;
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
        end else begin
            if (hs) begin
                op_a   <= req_a[int'(arb_id)*ADD_W +: ADD_W];
                op_b   <= req_b[int'(arb_id)*ADD_W +: ADD_W];
                op_cin <= req_cin[arb_id];
                op_id  <= arb_id;
                rr_ptr <= (arb_id == IDW'(NREQ-1)) ? '0 : arb_id + 1'b1;
            end
            if (state == EXEC) begin
                rsp_sum   <= add_sum;
                rsp_cout  <= add_cout;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_csl_add_arbiter.sv
// Randomized self-checking bench for csl_add_arbiter against a
// transaction-level model (plain integer addition, distance-based RR).
module tb_csl_add_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = 23;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic [NREQ-1:0]   req_cin;
    logic              rsp_valid, rsp_ready;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic [IDW-1:0]    rsp_id;
    logic              busy;

    int ntot  = 0;
    int npass = 0;
    int mptr  = 0;

    csl_add_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        for (int i = 0; i < NREQ; i++) begin
            req_a[W*i +: W] = W'($urandom);
            req_b[W*i +: W] = W'($urandom);
            req_cin[i]      = 1'($urandom);
        end
    endtask

    // Model: winner is the valid requester nearest to the pointer,
    // measured as forward distance modulo NREQ.
    function automatic int model_pick(input logic [NREQ-1:0] v);
        int best, bestd, d;
        best  = -1;
        bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            d = (i - mptr + NREQ) % NREQ;
            if (v[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    task automatic txn(input logic [NREQ-1:0] v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic c, input int bp);
        int g;
        logic [W:0] exp;
        logic [NREQ-1:0] eg;
        scramble();
        g  = model_pick(v);
        eg = (g < 0) ? '0 : NREQ'(1 << g);
        if (g >= 0) begin
            req_a[W*g +: W] = a;
            req_b[W*g +: W] = b;
            req_cin[g]      = c;
        end
        req_valid = v;
        rsp_ready = 1'($urandom);
        #1;
        ntot++;
        if (req_ready !== eg)
            $display("FAIL grant got %b exp %b v=%b", req_ready, eg, v);
        else npass++;
        if (g < 0) begin
            req_valid = '0;
            step();
            return;
        end
        exp  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        mptr = (g + 1) % NREQ;
        step();
        req_valid = '0;
        scramble();
        ntot++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== '0)
            $display("FAIL exec got busy=%b vld=%b rdy=%b exp 1 0 0",
                     busy, rsp_valid, req_ready);
        else npass++;
        step();
        ntot++;
        if (rsp_valid !== 1'b1 || {rsp_cout, rsp_sum} !== exp ||
            rsp_id !== IDW'(g))
            $display("FAIL rsp got v=%b %h id=%0d exp 1 %h id=%0d",
                     rsp_valid, {rsp_cout, rsp_sum}, rsp_id, exp, g);
        else npass++;
        for (int k = 0; k < bp; k++) begin
            rsp_ready = 1'b0;
            req_valid = NREQ'($urandom);
            #1;
            ntot++;
            if (req_ready !== '0)
                $display("FAIL bp_rdy got %b exp 0", req_ready);
            else npass++;
            step();
            ntot++;
            if (rsp_valid !== 1'b1 || {rsp_cout, rsp_sum} !== exp ||
                rsp_id !== IDW'(g))
                $display("FAIL bp_hold got %h id=%0d exp %h id=%0d",
                         {rsp_cout, rsp_sum}, rsp_id, exp, g);
            else npass++;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        ntot++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL retire got vld=%b busy=%b exp 0 0",
                     rsp_valid, busy);
        else npass++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst  = 1'b0;
        mptr = 0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b0;
        scramble();
        #3;
        ntot++;
        if ({rsp_valid, rsp_sum, rsp_cout, rsp_id, busy, req_ready} !== '0)
            $display("FAIL reset got v=%b s=%h c=%b id=%0d b=%b r=%b exp 0",
                     rsp_valid, rsp_sum, rsp_cout, rsp_id, busy, req_ready);
        else npass++;
        req_valid = '0;
        step();
        step();
        rst  = 1'b0;
        mptr = 0;
    endtask

    task automatic test_single();
        txn(4'b0100, 23'h000005, 23'h000003, 1'b1, 0);
    endtask

    task automatic test_carry();
        txn(4'b1000, 23'h7FFFFF, 23'h000001, 1'b0, 0);
        txn(4'b0001, 23'h7FFFFF, 23'h7FFFFF, 1'b1, 1);
    endtask

    task automatic test_round_robin();
        int g, pg;
        logic [W:0] exp, pexp;
        do_reset();
        rsp_ready = 1'b1;
        pg   = 0;
        pexp = '0;
        for (int k = 0; k < 5; k++) begin
            scramble();
            req_valid = '1;
            g = model_pick(4'b1111);
            exp = {1'b0, req_a[W*g +: W]} + {1'b0, req_b[W*g +: W]} +
                  {{W{1'b0}}, req_cin[g]};
            #1;
            ntot++;
            if (req_ready !== NREQ'(1 << (k % NREQ)) || g != k % NREQ)
                $display("FAIL rr_grant%0d got %b exp %b", k, req_ready,
                         NREQ'(1 << (k % NREQ)));
            else npass++;
            if (k > 0) begin
                ntot++;
                if (rsp_valid !== 1'b1 || rsp_id !== IDW'(pg) ||
                    {rsp_cout, rsp_sum} !== pexp)
                    $display("FAIL rr_rsp%0d got id=%0d %h exp id=%0d %h",
                             k, rsp_id, {rsp_cout, rsp_sum}, pg, pexp);
                else npass++;
            end
            mptr = (g + 1) % NREQ;
            pg   = g;
            pexp = exp;
            step();
            scramble();
            ntot++;
            if (req_ready !== '0 || rsp_valid !== 1'b0)
                $display("FAIL rr_exec%0d got rdy=%b vld=%b exp 0 0",
                         k, req_ready, rsp_valid);
            else npass++;
            step();
        end
        ntot++;
        if (rsp_valid !== 1'b1 || rsp_id !== IDW'(pg) ||
            {rsp_cout, rsp_sum} !== pexp)
            $display("FAIL rr_last got id=%0d %h exp id=%0d %h",
                     rsp_id, {rsp_cout, rsp_sum}, pg, pexp);
        else npass++;
        req_valid = '0;
        step();
    endtask

    task automatic test_backpressure();
        logic [W:0] exp0, exp1;
        logic [W+IDW:0] held;
        scramble();
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        exp0 = {1'b0, req_a[W-1:0]} + {1'b0, req_b[W-1:0]} +
               {{W{1'b0}}, req_cin[0]};
        mptr = 1;
        step();
        req_valid = 4'b0010;
        scramble();
        step();
        held = {rsp_cout, rsp_sum, rsp_id};
        ntot++;
        if (rsp_valid !== 1'b1 || held !== {exp0, 2'd0})
            $display("FAIL bp_first got %h exp %h", held, {exp0, 2'd0});
        else npass++;
        for (int k = 0; k < 5; k++) begin
            #1;
            ntot++;
            if (req_ready !== '0 || rsp_valid !== 1'b1 ||
                {rsp_cout, rsp_sum, rsp_id} !== held)
                $display("FAIL bp_stall%0d got rdy=%b %h exp 0 %h", k,
                         req_ready, {rsp_cout, rsp_sum, rsp_id}, held);
            else npass++;
            step();
        end
        rsp_ready = 1'b1;
        exp1 = {1'b0, req_a[W +: W]} + {1'b0, req_b[W +: W]} +
               {{W{1'b0}}, req_cin[1]};
        #1;
        ntot++;
        if (req_ready !== 4'b0010 || rsp_valid !== 1'b1)
            $display("FAIL b2b_grant got rdy=%b vld=%b exp 0010 1",
                     req_ready, rsp_valid);
        else npass++;
        mptr = 2;
        step();
        req_valid = '0;
        ntot++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL b2b_exec got vld=%b busy=%b exp 0 1",
                     rsp_valid, busy);
        else npass++;
        step();
        ntot++;
        if (rsp_valid !== 1'b1 || {rsp_cout, rsp_sum, rsp_id} !== {exp1, 2'd1})
            $display("FAIL b2b_rsp got %h exp %h",
                     {rsp_cout, rsp_sum, rsp_id}, {exp1, 2'd1});
        else npass++;
        step();
    endtask

    task automatic test_reset_mid();
        scramble();
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        step();
        req_valid = '1;
        #2;
        rst = 1'b1;
        #1;
        ntot++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0)
            $display("FAIL rst_mid got vld=%b busy=%b rdy=%b exp 0 0 0",
                     rsp_valid, busy, req_ready);
        else npass++;
        req_valid = '0;
        step();
        step();
        rst  = 1'b0;
        mptr = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            ntot++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0)
                $display("FAIL rst_quiet%0d got vld=%b busy=%b exp 0 0",
                         k, rsp_valid, busy);
            else npass++;
        end
        txn(4'b1111, W'($urandom), W'($urandom), 1'($urandom), 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++)
            txn(NREQ'($urandom), W'($urandom), W'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)));
    endtask

    initial begin
        req_a   = '0;
        req_b   = '0;
        req_cin = '0;
        test_reset();
        test_single();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
